// File: rtl/cordic_range_ctrl.sv
// Angle conditioning around a free-running CORDIC core: reduces a Q16.16 angle modulo 2*pi,
// folds it into [-pi/2, pi/2], and undoes the fold on the returning cosine.
module cordic_range_ctrl #(
    parameter int unsigned W         = 18,
    parameter int unsigned LAT       = 21,
    parameter int          PI_C      = 205887,
    parameter int          HALF_PI_C = 102944,
    parameter int          TWO_PI_C  = 411775
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  angle_in,
    output logic [W-1:0] angle_out,
    input  logic [W-1:0] sin_in,
    input  logic [W-1:0] cos_in,
    output logic         out_valid,
    output logic [W-1:0] sin_out,
    output logic [W-1:0] cos_out
);

    typedef enum logic [1:0] {StIdle, StReduce, StFold} state_e;

    localparam logic signed [32:0] PI_S      = 33'(PI_C);
    localparam logic signed [32:0] HALF_PI_S = 33'(HALF_PI_C);
    localparam logic signed [32:0] TWO_PI_S  = 33'(TWO_PI_C);
    localparam logic [32:0]        TWO_PI_U  = 33'(TWO_PI_C);

    state_e       state_q, state_d;
    logic [3:0]   k_q, k_d;
    logic [31:0]  r_q, r_d;
    logic         s_q, s_d;
    logic [W-1:0] angle_q, angle_d;
    logic         push;

    logic [32:0]        two_pi_shl;
    logic signed [32:0] fold_base;
    logic signed [32:0] fold_m;
    logic               fold_neg;
    logic               unused_fold_hi;

    // One stage more than LAT: angle_out is itself registered on the push edge.
    logic [LAT:0] tag_v_q;
    logic [LAT:0] tag_n_q;

    logic [W-1:0] sin_q, cos_q;
    logic         valid_q;

    assign two_pi_shl     = TWO_PI_U << k_q;
    assign unused_fold_hi = ^fold_m[32:W];

    always_comb begin
        fold_base = signed'({1'b0, r_q});
        if (fold_base > PI_S) begin
            fold_base = fold_base - TWO_PI_S;
        end
        if (s_q) begin
            fold_base = -fold_base;
        end
        fold_m   = fold_base;
        fold_neg = 1'b0;
        if (fold_base > HALF_PI_S) begin
            fold_m   = PI_S - fold_base;
            fold_neg = 1'b1;
        end else if (fold_base < -HALF_PI_S) begin
            fold_m   = -PI_S - fold_base;
            fold_neg = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        r_d     = r_q;
        s_d     = s_q;
        angle_d = angle_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    s_d     = angle_in[31];
                    r_d     = angle_in[31] ? (~angle_in + 32'd1) : angle_in;
                    k_d     = 4'd12;
                    state_d = StReduce;
                end
            end
            StReduce: begin
                // Restoring division by 2*pi, one quotient bit per cycle.
                if ({1'b0, r_q} >= two_pi_shl) begin
                    r_d = r_q - two_pi_shl[31:0];
                end
                k_d = k_q - 4'd1;
                if (k_q == 4'd0) begin
                    state_d = StFold;
                end
            end
            StFold: begin
                angle_d = fold_m[W-1:0];
                push    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            k_q     <= '0;
            r_q     <= '0;
            s_q     <= 1'b0;
            angle_q <= '0;
            tag_v_q <= '0;
            tag_n_q <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            r_q     <= r_d;
            s_q     <= s_d;
            angle_q <= angle_d;
            tag_v_q <= {tag_v_q[LAT-1:0], push};
            tag_n_q <= {tag_n_q[LAT-1:0], fold_neg};
            valid_q <= tag_v_q[LAT];
            if (tag_v_q[LAT]) begin
                sin_q <= sin_in;
                cos_q <= tag_n_q[LAT] ? -cos_in : cos_in;
            end
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign angle_out = angle_q;
    assign out_valid = valid_q;
    assign sin_out   = sin_q;
    assign cos_out   = cos_q;

endmodule

// File: tb/tb_cordic_range_ctrl.sv
// Bench for cordic_range_ctrl: behavioural CORDIC stand-in plus a reference model of the
// reduce/fold/latency rules, compared against the DUT every cycle.
module tb_cordic_range_ctrl;

    localparam int W      = 18;
    localparam int LAT    = 21;
    localparam int PI     = 205887;
    localparam int HALF   = 102944;
    localparam int TWO_PI = 411775;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  angle_in;
    logic [W-1:0] angle_out;
    logic [W-1:0] sin_in;
    logic [W-1:0] cos_in;
    logic         out_valid;
    logic [W-1:0] sin_out;
    logic [W-1:0] cos_out;

    cordic_range_ctrl #(
        .W(W),
        .LAT(LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .angle_in(angle_in),
        .angle_out(angle_out),
        .sin_in(sin_in),
        .cos_in(cos_in),
        .out_valid(out_valid),
        .sin_out(sin_out),
        .cos_out(cos_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string name, input int act, input int exp, input int tol);
        tests++;
        if (act - exp > tol || exp - act > tol) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d (tol %0d)",
                     name, cyc, act, exp, tol);
        end
    endtask

    function automatic int qsin(input int m);
        real y;
        y = $sin(real'(m) / 65536.0) * 65536.0;
        return $rtoi(y >= 0.0 ? y + 0.5 : y - 0.5);
    endfunction

    function automatic int qcos(input int m);
        real y;
        y = $cos(real'(m) / 65536.0) * 65536.0;
        return $rtoi(y >= 0.0 ? y + 0.5 : y - 0.5);
    endfunction

    // Reference reduction written with plain modulo arithmetic.
    function automatic void ref_fold(input logic [31:0] a, output int m, output bit neg);
        longint v;
        longint x;
        v = longint'($signed(a));
        x = (v < 0 ? -v : v) % TWO_PI;
        if (x > PI) x = x - TWO_PI;
        if (v < 0) x = -x;
        neg = 1'b0;
        if (x > HALF) begin
            x   = PI - x;
            neg = 1'b1;
        end else if (x < -HALF) begin
            x   = -PI - x;
            neg = 1'b1;
        end
        m = int'(x);
    endfunction

    // Stand-in CORDIC core: LAT-edge pipeline from angle_out to sin_in/cos_in.
    int ps[LAT];
    int pc[LAT];
    initial begin
        for (int i = 0; i < LAT; i++) begin
            ps[i] = 0;
            pc[i] = 0;
        end
        sin_in = '0;
        cos_in = '0;
        forever begin
            @(posedge clock);
            for (int i = LAT - 1; i > 0; i--) begin
                ps[i] = ps[i-1];
                pc[i] = pc[i-1];
            end
            ps[0] = qsin(int'($signed(angle_out)));
            pc[0] = qcos(int'($signed(angle_out)));
            sin_in <= W'(ps[LAT-1]);
            cos_in <= W'(pc[LAT-1]);
        end
    end

    typedef struct {
        int due;
        int s;
        int c;
    } exp_t;

    exp_t q[$];
    bit   started  = 1'b0;
    bit   busy     = 1'b0;
    int   fold_cyc = 0;
    int   pm       = 0;
    bit   pn       = 1'b0;
    int   exp_angle = 0;
    bit   exp_ov    = 1'b0;
    int   exp_so    = 0;
    int   exp_co    = 0;

    // Reference model: timing rules expressed as cycle offsets from the accept edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            cyc++;
            if (!reset) begin
                started   = 1'b1;
                q.delete();
                busy      = 1'b0;
                exp_angle = 0;
                exp_ov    = 1'b0;
                exp_so    = 0;
                exp_co    = 0;
            end else begin
                exp_ov = 1'b0;
                if (q.size() > 0 && q[0].due == cyc) begin
                    exp_ov = 1'b1;
                    exp_so = q[0].s;
                    exp_co = q[0].c;
                    void'(q.pop_front());
                end
                if (busy && fold_cyc == cyc) begin
                    exp_angle = pm;
                    e.due = cyc + LAT + 1;
                    e.s   = qsin(pm);
                    e.c   = pn ? -qcos(pm) : qcos(pm);
                    q.push_back(e);
                    busy = 1'b0;
                end else if (!busy && in_valid) begin
                    ref_fold(angle_in, pm, pn);
                    busy     = 1'b1;
                    fold_cyc = cyc + 14;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("in_ready", int'(in_ready), int'(!busy), 0);
            chk("out_valid", int'(out_valid), int'(exp_ov), 0);
            chk("angle_out", int'($signed(angle_out)), exp_angle, 0);
            chk("sin_out", int'($signed(sin_out)), exp_so, 4);
            chk("cos_out", int'($signed(cos_out)), exp_co, 4);
        end
    end

    task automatic wait_accept(output int acc);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        acc = cyc;
        if (!got) chk("accept timeout", 0, 1, 0);
    endtask

    task automatic wait_out(output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (out_valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("out_valid timeout", 0, 1, 0);
    endtask

    task automatic realign();
        @(posedge clock);
        #1;
    endtask

    task automatic one_angle(input logic [31:0] a, input string name, input int exp_ang,
                             input int exp_s, input int exp_c);
        int acc;
        int at;
        in_valid = 1'b1;
        angle_in = a;
        wait_accept(acc);
        in_valid = 1'b0;
        wait_out(at);
        chk({name, " latency"}, at - acc, 36, 0);
        chk({name, " angle_out"}, int'($signed(angle_out)), exp_ang, 0);
        chk({name, " sin_out"}, int'($signed(sin_out)), exp_s, 4);
        chk({name, " cos_out"}, int'($signed(cos_out)), exp_c, 4);
        realign();
    endtask

    initial begin
        int  m;
        bit  n;
        int  a1, a2, o1, o2, cnt;
        reset    = 1'b0;
        in_valid = 1'b0;
        angle_in = '0;

        ref_fold(32'd0, m, n);
        chk("model 0 m", m, 0, 0);
        chk("model 0 neg", int'(n), 0, 0);
        ref_fold(32'd205887, m, n);
        chk("model pi m", m, 0, 0);
        chk("model pi neg", int'(n), 1, 0);
        ref_fold(32'd411776, m, n);
        chk("model 2pi+1 m", m, 1, 0);
        ref_fold(-32'sd154415, m, n);
        chk("model -3pi/4 m", m, -51472, 0);
        chk("model -3pi/4 neg", int'(n), 1, 0);
        chk("model -3pi/4 sin", qsin(m), -46341, 4);
        ref_fold(32'h8000_0000, m, n);
        chk("model min m", m, -77023, 0);
        chk("model min neg", int'(n), 0, 0);

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("reset in_ready", int'(in_ready), 1, 0);
        chk("reset out_valid", int'(out_valid), 0, 0);
        realign();

        one_angle(32'd0, "zero", 0, 0, 65536);
        one_angle(32'd205887, "pi", 0, 0, -65536);
        one_angle(32'd411776, "2pi+1", 1, 1, 65536);
        one_angle(-32'sd154415, "-3pi/4", -51472, -46341, -46341);
        one_angle(32'h8000_0000, "int_min", -77023, qsin(-77023), qcos(-77023));

        // Back-to-back: in_valid held across both accepts.
        in_valid = 1'b1;
        angle_in = 32'd0;
        wait_accept(a1);
        angle_in = 32'd205887;
        wait_accept(a2);
        in_valid = 1'b0;
        chk("b2b accept gap", a2 - a1, 15, 0);
        wait_out(o1);
        chk("b2b first cos", int'($signed(cos_out)), 65536, 4);
        realign();
        wait_out(o2);
        chk("b2b second cos", int'($signed(cos_out)), -65536, 4);
        chk("b2b first latency", o1 - a1, 36, 0);
        chk("b2b out gap", o2 - o1, 15, 0);
        realign();

        // Reset mid-REDUCE with an earlier tag still in flight.
        in_valid = 1'b1;
        angle_in = -32'sd154415;
        wait_accept(a1);
        angle_in = 32'd77777;
        wait_accept(a2);
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b0;
        realign();
        reset = 1'b1;
        @(negedge clock);
        chk("post-reset in_ready", int'(in_ready), 1, 0);
        chk("post-reset angle_out", int'($signed(angle_out)), 0, 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (out_valid) cnt++;
        end
        chk("post-reset no out_valid", cnt, 0, 0);
        realign();

        // Random traffic, including ignored in_valid while busy and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) angle_in = $urandom;
            else angle_in = 32'($signed($urandom_range(0, 1800000)) - 900000);
            reset = ($urandom_range(0, 299) != 0);
            realign();
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (60) @(posedge clock);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
